data_bus_master_arbiter: RTL and testbench
==========================================

# data_bus_master_arbiter

Two-master to one-slave arbiter for the SoC `data_bus` protocol (req/gnt request phase, rvalid/rdata response phase). It sits between the core data port plus a second bus master (DMA / debug module) and the existing data bus address decoder, so both masters share the peripheral and memory map. It supports one outstanding transaction at a time, with fixed or round-robin priority, and routes each response back to the master that issued the request.

## Interface
- `ROUND_ROBIN`, default 1: 1 = alternate priority after every granted transaction; 0 = fixed priority, m0 always wins.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m0_dbus` data_bus.slave: master 0 (core data port): req, we, be[3:0], addr[31:0], wdata[31:0] in; gnt, rvalid, rdata[31:0] out.
- `m1_dbus` data_bus.slave: master 1 (DMA/debug), same signals as m0_dbus.
- `s_dbus` data_bus.master: shared downstream bus to the address decoder.
- `owner` out 1: master currently holding the bus (0/1). Registered.
- `busy` out 1: state != IDLE. Derived from registered state.

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RSP. Registered `owner_q` and `prio_q`; `prio_q` is the master preferred on a tie.
- **IDLE**
  - Winner is the requesting master if only one requests. On a tie, the winner is `prio_q` (RR) or m0 (fixed).
  - Forward the winner's req/we/be/addr/wdata to s_dbus. Drive winner.gnt = s_dbus.gnt; loser.gnt = 0.
  - If s_dbus.gnt: go to WAIT_RSP, set owner_q = winner, and if ROUND_ROBIN set prio_q = ~winner.
  - If no gnt: go to WAIT_GNT and set owner_q = winner.
  - If there is no request: s_dbus request signals all zero; stay in IDLE.
- **WAIT_GNT**
  - Locked to owner_q; no re-arbitration even if the other master requests.
  - Forward owner's request signals and gnt. On gnt: go to WAIT_RSP and update prio_q as in IDLE.
  - If the owner drops req (protocol violation): s_dbus.req = 0 and return to IDLE; prio_q unchanged.
- **WAIT_RSP**
  - s_dbus request signals zero; gnt = 0 to both masters.
  - owner.rvalid/rdata = s_dbus.rvalid/rdata. Non-owner rvalid = 0, rdata = 0.
  - On s_dbus.rvalid: return to IDLE.
- Outside WAIT_RSP, both masters see rvalid = 0 and rdata = 0. An s_dbus.rvalid arriving in IDLE or WAIT_GNT is dropped.
- The non-winning master's gnt is always 0. Its request is held by protocol and is served on a later IDLE cycle.

## Timing
- Reset values: state = IDLE, owner_q = 0, prio_q = 0 (m0 preferred), owner = 0, busy = 0.
- Reset outputs: all s_dbus outputs 0; all master gnt, rvalid and rdata 0.
- The request path (m*.req/addr to s_dbus) and the gnt path (s_dbus.gnt to m*.gnt) are combinational, with zero added latency.
- The response path (s_dbus.rvalid/rdata to owner) is combinational.
- Minimum transaction period is 2 cycles:
  - cycle N: IDLE, gnt.
  - cycle N+1: WAIT_RSP, rvalid.
  - cycle N+2: IDLE, next gnt possible.
- With both masters requesting continuously under RR, grants alternate m0, m1, m0, ... every 2 cycles. Under fixed priority, m1 is starved while m0 requests.
- Reset mid-transaction immediately forces IDLE and zeroes all outputs. A pending response is lost.

## Test plan
- **Reset:** assert rst_n = 0 during WAIT_RSP with the owner = m1 → immediately busy = 0, owner = 0, all gnt/rvalid = 0; after release, m0 wins a tie.
- **Single master:** m1 writes addr 0x0001_0004, wdata 0xDEAD_BEEF, be 4'hF; slave gnt same cycle, rvalid next → s_dbus carries exactly those values; m1.gnt at cycle 0, m1.rvalid at cycle 1; m0 sees no gnt/rvalid.
- **Round-robin tie:** ROUND_ROBIN = 1, both masters request continuously, slave gnt=1 with rvalid 1 cycle later → grant order m0, m1, m0, m1 at cycles 0, 2, 4, 6.
- **Fixed priority:** ROUND_ROBIN = 0, same stimulus → m0 granted every 2 cycles; m1.gnt stays 0 until m0 deasserts req, then m1 is granted in the next IDLE cycle.
- **Wait states:** slave withholds gnt for 3 cycles while m1 starts requesting in cycle 1 → bus stays locked to m0, m1.gnt = 0 throughout; m0 read rdata 0x1234_5678 after 2 wait cycles is routed only to m0; m1 is granted next.
- **Stray and abort:** stray s_dbus.rvalid in IDLE → no master sees rvalid. Owner drops req in WAIT_GNT → state returns to IDLE and prio_q is unchanged.

Source files
------------

// File: rtl/data_bus_master_arbiter_if.sv
// data_bus: req/gnt request phase, rvalid/rdata response phase.
// master drives the request, slave answers with gnt and the response.
interface data_bus;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/data_bus_master_arbiter.sv
// Two-master to one-slave data_bus arbiter, one outstanding transaction.
// Fixed or round-robin priority; responses routed back to the owner.
module data_bus_master_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  data_bus.slave  m0_dbus,
  data_bus.slave  m1_dbus,
  data_bus.master s_dbus,
  output logic owner,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RSP
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q, prio_d;
  logic   fwd;
  logic   sel;
  logic   win;
  logic   own_req;

  // State, owner and tie-break preference registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  // Arbitration, next state and all bus routing.
  // Outputs are forced to zero while reset is asserted.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    fwd     = 1'b0;
    sel     = owner_q;
    win     = 1'b0;
    own_req = owner_q ? m1_dbus.req : m0_dbus.req;

    s_dbus.req     = 1'b0;
    s_dbus.we      = 1'b0;
    s_dbus.be      = 4'h0;
    s_dbus.addr    = 32'h0;
    s_dbus.wdata   = 32'h0;
    m0_dbus.gnt    = 1'b0;
    m0_dbus.rvalid = 1'b0;
    m0_dbus.rdata  = 32'h0;
    m1_dbus.gnt    = 1'b0;
    m1_dbus.rvalid = 1'b0;
    m1_dbus.rdata  = 32'h0;

    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (m0_dbus.req || m1_dbus.req) begin
            if (m0_dbus.req && m1_dbus.req)
              win = ROUND_ROBIN ? prio_q : 1'b0;
            else
              win = m1_dbus.req;
            fwd     = 1'b1;
            sel     = win;
            owner_d = win;
            if (s_dbus.gnt) begin
              state_d = WAIT_RSP;
              if (ROUND_ROBIN)
                prio_d = ~win;
            end else begin
              state_d = WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          if (own_req) begin
            fwd = 1'b1;
            if (s_dbus.gnt) begin
              state_d = WAIT_RSP;
              if (ROUND_ROBIN)
                prio_d = ~owner_q;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_RSP: begin
          if (owner_q) begin
            m1_dbus.rvalid = s_dbus.rvalid;
            m1_dbus.rdata  = s_dbus.rdata;
          end else begin
            m0_dbus.rvalid = s_dbus.rvalid;
            m0_dbus.rdata  = s_dbus.rdata;
          end
          if (s_dbus.rvalid)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (fwd) begin
        if (sel) begin
          s_dbus.req   = m1_dbus.req;
          s_dbus.we    = m1_dbus.we;
          s_dbus.be    = m1_dbus.be;
          s_dbus.addr  = m1_dbus.addr;
          s_dbus.wdata = m1_dbus.wdata;
          m1_dbus.gnt  = s_dbus.gnt;
        end else begin
          s_dbus.req   = m0_dbus.req;
          s_dbus.we    = m0_dbus.we;
          s_dbus.be    = m0_dbus.be;
          s_dbus.addr  = m0_dbus.addr;
          s_dbus.wdata = m0_dbus.wdata;
          m0_dbus.gnt  = s_dbus.gnt;
        end
      end
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_data_bus_master_arbiter.sv
// Bench for data_bus_master_arbiter: RR and fixed instances share stimulus.
// Directed vector table, hand sequences, then random vs. a reference model.
module tb_data_bus_master_arbiter;

  typedef struct packed {
    logic        r0;
    logic        we0;
    logic [3:0]  be0;
    logic [31:0] a0;
    logic [31:0] wd0;
    logic        r1;
    logic        we1;
    logic [3:0]  be1;
    logic [31:0] a1;
    logic [31:0] wd1;
    logic        sg;
    logic        srv;
    logic [31:0] srd;
  } in_t;

  typedef struct packed {
    logic        s_req;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        g0;
    logic        g1;
    logic        v0;
    logic        v1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        own;
    logic        busy;
  } obs_t;

  // Abstract model state: lock = master holding the bus (-1 = free),
  // rsp = its request was accepted, pref = tie winner, own = last owner.
  typedef struct {
    int lock;
    bit rsp;
    bit pref;
    bit own;
  } mst_t;

  typedef struct {
    bit rs, fx, r0, r1;
    logic [31:0] a0, a1;
    bit g, rv;
    logic [31:0] rd;
    logic [102:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  ti;
  obs_t obs_rr, obs_fx;
  logic own_rr, busy_rr, own_fx, busy_fx;
  int   nerr = 0;
  int   nchk = 0;

  always #5 clk = ~clk;

  data_bus m0_rr();
  data_bus m1_rr();
  data_bus s_rr();
  data_bus m0_fx();
  data_bus m1_fx();
  data_bus s_fx();

  assign m0_rr.req = ti.r0;
  assign m0_rr.we = ti.we0;
  assign m0_rr.be = ti.be0;
  assign m0_rr.addr = ti.a0;
  assign m0_rr.wdata = ti.wd0;
  assign m1_rr.req = ti.r1;
  assign m1_rr.we = ti.we1;
  assign m1_rr.be = ti.be1;
  assign m1_rr.addr = ti.a1;
  assign m1_rr.wdata = ti.wd1;
  assign s_rr.gnt = ti.sg;
  assign s_rr.rvalid = ti.srv;
  assign s_rr.rdata = ti.srd;

  assign m0_fx.req = ti.r0;
  assign m0_fx.we = ti.we0;
  assign m0_fx.be = ti.be0;
  assign m0_fx.addr = ti.a0;
  assign m0_fx.wdata = ti.wd0;
  assign m1_fx.req = ti.r1;
  assign m1_fx.we = ti.we1;
  assign m1_fx.be = ti.be1;
  assign m1_fx.addr = ti.a1;
  assign m1_fx.wdata = ti.wd1;
  assign s_fx.gnt = ti.sg;
  assign s_fx.rvalid = ti.srv;
  assign s_fx.rdata = ti.srd;

  data_bus_master_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_dbus(m0_rr), .m1_dbus(m1_rr), .s_dbus(s_rr),
    .owner(own_rr), .busy(busy_rr)
  );

  data_bus_master_arbiter #(.ROUND_ROBIN(1'b0)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .m0_dbus(m0_fx), .m1_dbus(m1_fx), .s_dbus(s_fx),
    .owner(own_fx), .busy(busy_fx)
  );

  assign obs_rr = {s_rr.req, s_rr.we, s_rr.be, s_rr.addr, s_rr.wdata,
                   m0_rr.gnt, m1_rr.gnt, m0_rr.rvalid, m1_rr.rvalid,
                   m0_rr.rdata, m1_rr.rdata, own_rr, busy_rr};
  assign obs_fx = {s_fx.req, s_fx.we, s_fx.be, s_fx.addr, s_fx.wdata,
                   m0_fx.gnt, m1_fx.gnt, m0_fx.rvalid, m1_fx.rvalid,
                   m0_fx.rdata, m1_fx.rdata, own_fx, busy_fx};

  task automatic chk(input string nm, input logic [159:0] got,
                     input logic [159:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ti.r0 = 1'b0;
    ti.r1 = 1'b0;
    ti.sg = 1'b0;
    ti.srv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: one transaction at a time; a free bus goes to the sole
  // requester or, on a tie, to pref (RR) / m0 (fixed).
  function automatic void model(input bit rr, input mst_t st, input in_t i,
                                output obs_t o, output mst_t nx);
    int cand;
    bit [1:0] rq;
    o = '0;
    nx = st;
    rq = {i.r1, i.r0};
    o.own = st.own;
    o.busy = (st.lock >= 0);
    if (st.rsp) begin
      if (st.lock == 0) begin
        o.v0 = i.srv;
        o.d0 = i.srd;
      end else begin
        o.v1 = i.srv;
        o.d1 = i.srd;
      end
      if (i.srv) begin
        nx.lock = -1;
        nx.rsp = 1'b0;
      end
    end else begin
      if (st.lock >= 0) cand = rq[st.lock] ? st.lock : -1;
      else if (i.r0 && i.r1) cand = rr ? int'(st.pref) : 0;
      else if (i.r0) cand = 0;
      else if (i.r1) cand = 1;
      else cand = -1;
      nx.lock = cand;
      if (cand >= 0) begin
        o.s_req = 1'b1;
        o.s_we = (cand == 1) ? i.we1 : i.we0;
        o.s_be = (cand == 1) ? i.be1 : i.be0;
        o.s_addr = (cand == 1) ? i.a1 : i.a0;
        o.s_wdata = (cand == 1) ? i.wd1 : i.wd0;
        if (cand == 1) o.g1 = i.sg;
        else o.g0 = i.sg;
        nx.own = (cand == 1);
        if (i.sg) begin
          nx.rsp = 1'b1;
          if (rr) nx.pref = (cand == 0);
        end
      end
    end
  endfunction

  function automatic vec_t mk(
    bit rs, bit fx, bit r0, bit r1, logic [31:0] a0, logic [31:0] a1,
    bit g, bit rv, logic [31:0] rd,
    bit eg0, bit eg1, bit ev0, bit ev1, bit eown, bit ebusy, bit esreq,
    logic [31:0] esa, logic [31:0] ed0, logic [31:0] ed1);
    vec_t v;
    v.rs = rs; v.fx = fx; v.r0 = r0; v.r1 = r1;
    v.a0 = a0; v.a1 = a1; v.g = g; v.rv = rv; v.rd = rd;
    v.exp = {eg0, eg1, ev0, ev1, eown, ebusy, esreq, esa, ed0, ed1};
    return v;
  endfunction

  localparam logic [31:0] A = 32'h0000_0100;
  localparam logic [31:0] B = 32'h0000_0200;
  localparam logic [31:0] SA = 32'h0001_0004;

  vec_t tbl[$];
  mst_t st_rr, st_fx, nx_rr, nx_fx;
  obs_t e_rr, e_fx;
  obs_t o;

  initial begin
    ti = '0;
    ti.be0 = 4'hF;
    ti.we1 = 1'b1;
    ti.be1 = 4'hF;
    ti.wd1 = 32'hDEAD_BEEF;

    // single master m1
    tbl.push_back(mk(1,0, 0,1,0,SA, 1,0,0, 0,1,0,0,0,0,1,SA,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,1,32'hCAFE0001, 0,0,0,1,1,1,0,0,0,32'hCAFE0001));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0,0, 0,0,0,0,1,0,0,0,0,0));
    // round-robin tie
    tbl.push_back(mk(1,0, 1,1,A,B, 1,0,0, 1,0,0,0,0,0,1,A,0,0));
    tbl.push_back(mk(0,0, 1,1,A,B, 1,1,32'h11, 0,0,1,0,0,1,0,0,32'h11,0));
    tbl.push_back(mk(0,0, 1,1,A,B, 1,0,0, 0,1,0,0,0,0,1,B,0,0));
    tbl.push_back(mk(0,0, 1,1,A,B, 1,1,32'h22, 0,0,0,1,1,1,0,0,0,32'h22));
    tbl.push_back(mk(0,0, 1,1,A,B, 1,0,0, 1,0,0,0,1,0,1,A,0,0));
    tbl.push_back(mk(0,0, 1,1,A,B, 1,1,32'h33, 0,0,1,0,0,1,0,0,32'h33,0));
    tbl.push_back(mk(0,0, 1,1,A,B, 1,0,0, 0,1,0,0,0,0,1,B,0,0));
    tbl.push_back(mk(0,0, 1,1,A,B, 1,1,32'h44, 0,0,0,1,1,1,0,0,0,32'h44));
    // fixed priority
    tbl.push_back(mk(1,1, 1,1,A,B, 1,0,0, 1,0,0,0,0,0,1,A,0,0));
    tbl.push_back(mk(0,1, 1,1,A,B, 1,1,32'h55, 0,0,1,0,0,1,0,0,32'h55,0));
    tbl.push_back(mk(0,1, 1,1,A,B, 1,0,0, 1,0,0,0,0,0,1,A,0,0));
    tbl.push_back(mk(0,1, 1,1,A,B, 1,1,32'h66, 0,0,1,0,0,1,0,0,32'h66,0));
    tbl.push_back(mk(0,1, 0,1,A,B, 1,0,0, 0,1,0,0,0,0,1,B,0,0));
    tbl.push_back(mk(0,1, 0,0,A,B, 0,1,32'h77, 0,0,0,1,1,1,0,0,0,32'h77));
    // wait states: locked to m0, m1 waits
    tbl.push_back(mk(1,0, 1,0,A,B, 0,0,0, 0,0,0,0,0,0,1,A,0,0));
    tbl.push_back(mk(0,0, 1,1,A,B, 0,0,0, 0,0,0,0,0,1,1,A,0,0));
    tbl.push_back(mk(0,0, 1,1,A,B, 0,0,0, 0,0,0,0,0,1,1,A,0,0));
    tbl.push_back(mk(0,0, 1,1,A,B, 1,0,0, 1,0,0,0,0,1,1,A,0,0));
    tbl.push_back(mk(0,0, 0,1,A,B, 0,0,0, 0,0,0,0,0,1,0,0,0,0));
    tbl.push_back(mk(0,0, 0,1,A,B, 0,0,0, 0,0,0,0,0,1,0,0,0,0));
    tbl.push_back(mk(0,0, 0,1,A,B, 0,1,32'h12345678, 0,0,1,0,0,1,0,0,32'h12345678,0));
    tbl.push_back(mk(0,0, 0,1,A,B, 1,0,0, 0,1,0,0,0,0,1,B,0,0));

    do_reset();
    chk("reset_rr", obs_rr, '0);
    chk("reset_fx", obs_fx, '0);

    foreach (tbl[k]) begin
      if (tbl[k].rs) do_reset();
      ti.r0 = tbl[k].r0;
      ti.r1 = tbl[k].r1;
      ti.a0 = tbl[k].a0;
      ti.a1 = tbl[k].a1;
      ti.sg = tbl[k].g;
      ti.srv = tbl[k].rv;
      ti.srd = tbl[k].rd;
      #1;
      o = tbl[k].fx ? obs_fx : obs_rr;
      chk($sformatf("vec%0d", k),
          {o.g0, o.g1, o.v0, o.v1, o.own, o.busy, o.s_req, o.s_addr, o.d0, o.d1},
          tbl[k].exp);
      @(negedge clk);
    end

    // single master: write payload passes through unchanged
    do_reset();
    ti.r1 = 1'b1;
    ti.a1 = SA;
    ti.sg = 1'b1;
    #1;
    chk("sm_payload", {s_rr.we, s_rr.be, s_rr.wdata, m0_rr.gnt},
        {1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0});

    // reset during WAIT_RSP owned by m1
    @(negedge clk);
    ti.r0 = 1'b1;
    ti.a0 = 32'h0000_0300;
    ti.srv = 1'b1;
    ti.srd = 32'hA5A5_A5A5;
    #1;
    chk("rst_pre", {own_rr, busy_rr, m1_rr.rvalid}, 3'b111);
    rst_n = 1'b0;
    #1;
    chk("rst_rr", obs_rr, '0);
    chk("rst_fx", obs_fx, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ti.srv = 1'b0;
    #1;
    chk("rst_tie", {m0_rr.gnt, m1_rr.gnt, s_rr.addr},
        {1'b1, 1'b0, 32'h0000_0300});
    @(negedge clk);

    // stray rvalid in IDLE
    do_reset();
    ti.srv = 1'b1;
    ti.srd = 32'hFFFF_0000;
    #1;
    chk("stray", {m0_rr.rvalid, m1_rr.rvalid, m0_rr.rdata, m1_rr.rdata, busy_rr},
        '0);
    @(negedge clk);

    // abort in WAIT_GNT keeps the preference
    ti.srv = 1'b0;
    ti.r0 = 1'b1;
    ti.a0 = A;
    ti.sg = 1'b1;
    @(negedge clk);
    ti.r0 = 1'b0;
    ti.sg = 1'b0;
    ti.srv = 1'b1;
    @(negedge clk);
    ti.srv = 1'b0;
    ti.r1 = 1'b1;
    ti.a1 = B;
    #1;
    chk("abort_wait", {m1_rr.gnt, s_rr.req}, 2'b01);
    @(negedge clk);
    ti.r1 = 1'b0;
    #1;
    chk("abort_drop", {s_rr.req, busy_rr, own_rr}, 3'b011);
    @(negedge clk);
    ti.r0 = 1'b1;
    ti.r1 = 1'b1;
    ti.sg = 1'b1;
    #1;
    chk("abort_prio", {busy_rr, m0_rr.gnt, m1_rr.gnt, s_rr.addr},
        {1'b0, 1'b0, 1'b1, B});
    @(negedge clk);

    // random traffic against the reference model
    do_reset();
    st_rr = '{lock: -1, rsp: 1'b0, pref: 1'b0, own: 1'b0};
    st_fx = st_rr;
    for (int n = 0; n < 1500; n++) begin
      ti.r0 = ($urandom_range(3) != 0);
      ti.r1 = ($urandom_range(3) != 0);
      ti.we0 = 1'($urandom);
      ti.we1 = 1'($urandom);
      ti.be0 = 4'($urandom);
      ti.be1 = 4'($urandom);
      ti.a0 = $urandom;
      ti.a1 = $urandom;
      ti.wd0 = $urandom;
      ti.wd1 = $urandom;
      ti.sg = 1'($urandom);
      ti.srv = 1'($urandom);
      ti.srd = $urandom;
      #1;
      model(1'b1, st_rr, ti, e_rr, nx_rr);
      model(1'b0, st_fx, ti, e_fx, nx_fx);
      chk("rnd_rr", obs_rr, e_rr);
      chk("rnd_fx", obs_fx, e_fx);
      st_rr = nx_rr;
      st_fx = nx_fx;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
